pc_gen: RTL and testbench

- Program-counter generator directly upstream of the fetch stage.
- Produces the fetch address (`target`) consumed by ifetch each cycle, advances it sequentially, and applies redirects from execute.
- Tracks outstanding fetches so that responses belonging to a squashed path are marked killed.
- Returns the PC that matches each accepted response to decode.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/pc_queue.sv | 61 ++++++
 rtl/pc_gen.sv | 63 ++++++
 tb/tb_pc_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the fetch front end
package cpu_pkg;
   localparam int XLEN = 32;
   typedef logic [XLEN-1:0] pc_t;
   typedef enum logic [1:0] {BOOT, RUN, HOLD, FLUSH} pcgen_state_e;
   localparam int PC_INC = 4;
   localparam pc_t RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/pc_queue.sv
// pc_queue: in-order FIFO of {pc, kill} for fetches issued but not yet returned
module pc_queue
   import cpu_pkg::*;
#(
   parameter int xlen = XLEN,
   parameter int DEPTH = 2,
   parameter logic [xlen-1:0] RESET_PC = cpu_pkg::RESET_VECTOR,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_push,
   input  logic [xlen-1:0] i_pc,
   input  logic            i_pop,
   input  logic            i_kill_all,
   output logic [xlen-1:0] o_head_pc,
   output logic            o_head_kill,
   output logic [CW-1:0]   o_count,
   output logic            o_empty,
   output logic            o_full
);
   logic [xlen-1:0] r_pcs [DEPTH];
   logic [xlen-1:0] w_up_pc [DEPTH];
   logic [DEPTH-1:0] r_kill;
   logic [DEPTH-1:0] w_up_kill;
   logic [CW-1:0] r_count, w_left, w_count_n;
   logic w_pop, w_push;
   assign w_pop = i_pop && r_count != '0;
   assign w_left = r_count - CW'(w_pop);
   assign w_push = i_push && w_left != CW'(DEPTH);
   assign w_count_n = w_left + CW'(w_push);
   assign w_up_kill = r_kill >> 1;
   for (genvar g = 0; g < DEPTH; g++) begin : g_up
      if (g < DEPTH - 1) begin : g_mid
         assign w_up_pc[g] = r_pcs[g+1];
      end else begin : g_last
         assign w_up_pc[g] = '0;
      end
   end
   // Popping shifts every entry toward slot 0; kill_all marks only slots still valid afterwards
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_kill <= '0;
         for (int i = 0; i < DEPTH; i++) r_pcs[i] <= RESET_PC;
      end else begin
         r_count <= w_count_n;
         for (int i = 0; i < DEPTH; i++) begin
            r_pcs[i] <= (w_push && CW'(i) == w_left) ? i_pc : w_pop ? w_up_pc[i] : r_pcs[i];
            r_kill[i] <= i_kill_all ? CW'(i) < w_count_n
                       : (w_push && CW'(i) == w_left) ? 1'b0
                       : w_pop ? w_up_kill[i] : r_kill[i];
         end
      end
   end
   assign o_head_pc = r_pcs[0];
   assign o_head_kill = r_kill[0];
   assign o_count = r_count;
   assign o_empty = r_count == '0;
   assign o_full = r_count == CW'(DEPTH);
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with redirect/flush tracking of in-flight fetches.
// Define PC_GEN_RVC_EN to accept 16-bit aligned redirect targets.
module pc_gen
   import cpu_pkg::*;
#(
   parameter int xlen = XLEN,
   parameter logic [xlen-1:0] RESET_VECTOR = cpu_pkg::RESET_VECTOR,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [xlen-1:0] target,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   input  logic            resp_valid,
   output logic [xlen-1:0] resp_pc,
   output logic            resp_kill,
   input  logic            stall,
   input  logic            redirect,
   input  logic [xlen-1:0] redirect_pc,
   output logic            misalign
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   pcgen_state_e r_state, w_state_n;
   logic [xlen-1:0] r_pc;
   logic [CW-1:0] w_count, w_left;
   logic w_aligned, w_active, w_redir, w_pop, w_issue, w_empty, w_full;
`ifdef PC_GEN_RVC_EN
   assign w_aligned = ~redirect_pc[0];
`else
   assign w_aligned = redirect_pc[1:0] == 2'b00;
`endif
   assign w_active = r_state != BOOT;
   assign w_redir = redirect && w_aligned && w_active;
   assign misalign = redirect && !w_aligned && w_active;
   assign w_pop = resp_valid && !w_empty;
   assign fetch_valid = r_state == RUN && !stall && !w_full && !w_redir;
   assign w_issue = fetch_valid && fetch_ready;
   assign w_left = w_count - CW'(w_pop);
   assign target = r_pc;
   // Once no fetches remain in flight every killed response has drained
   always_comb begin
      w_state_n = r_state == BOOT ? RUN
                : (w_redir || r_state == FLUSH) ? (w_left != '0 ? FLUSH : RUN)
                : stall ? HOLD : RUN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BOOT;
         r_pc <= RESET_VECTOR;
      end else begin
         r_state <= w_state_n;
         r_pc <= w_redir ? redirect_pc : w_issue ? r_pc + xlen'(PC_INC) : r_pc;
      end
   end
   pc_queue #(.xlen(xlen), .DEPTH(MAX_OUTSTANDING), .RESET_PC(RESET_VECTOR)) u_queue (
      .clk(clk), .rst(rst),
      .i_push(w_issue), .i_pc(r_pc), .i_pop(resp_valid), .i_kill_all(w_redir),
      .o_head_pc(resp_pc), .o_head_kill(resp_kill),
      .o_count(w_count), .o_empty(w_empty), .o_full(w_full)
   );
   a_resp_needs_entry: assert property (@(posedge clk) disable iff (rst) resp_valid |-> !w_empty);
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table, corner sequences and randomized model check of pc_gen
module tb_pc_gen;
   localparam int MAX = 2;
   localparam logic [31:0] RV = 32'h0000_0000;
`ifdef PC_GEN_RVC_EN
   localparam logic [31:0] PD = 32'h102;
`else
   localparam logic [31:0] PD = 32'h304;
`endif
   logic clk = 0, rst = 1;
   logic fetch_ready = 0, resp_valid = 0, stall = 0, redirect = 0;
   logic [31:0] redirect_pc = 0, target, resp_pc;
   logic fetch_valid, resp_kill, misalign;
   int n_pass = 0, n_chk = 0;
   typedef struct {
      logic rdy, rv, st, rd;
      logic [31:0] rpc;
      logic efv;
      logic [31:0] etgt, erpc;
      logic ekill, emis;
   } vec_t;
   typedef struct {
      logic [31:0] pc;
      logic kill;
   } ent_t;
   vec_t tbl[$];
   logic [31:0] m_pc;
   ent_t m_q[$];
   bit m_boot, m_hold;

   pc_gen #(.xlen(32), .RESET_VECTOR(RV), .MAX_OUTSTANDING(MAX)) dut (
      .clk(clk), .rst(rst), .target(target), .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready), .resp_valid(resp_valid), .resp_pc(resp_pc),
      .resp_kill(resp_kill), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .misalign(misalign)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rdy, rv, st, rd, logic [31:0] rpc, logic efv,
                               logic [31:0] etgt, erpc, logic ekill, emis);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.st = st; v.rd = rd; v.rpc = rpc;
      v.efv = efv; v.etgt = etgt; v.erpc = erpc; v.ekill = ekill; v.emis = emis;
      return v;
   endfunction

   function automatic bit aligned(logic [31:0] a);
`ifdef PC_GEN_RVC_EN
      return a[0] == 1'b0;
`else
      return a[1:0] == 2'b00;
`endif
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic step(string nm, vec_t v);
      @(negedge clk);
      rst = 0; fetch_ready = v.rdy; resp_valid = v.rv; stall = v.st;
      redirect = v.rd; redirect_pc = v.rpc;
      #1;
      chk($sformatf("%s fetch_valid", nm), 32'(fetch_valid), 32'(v.efv));
      chk($sformatf("%s target", nm), target, v.etgt);
      chk($sformatf("%s misalign", nm), 32'(misalign), 32'(v.emis));
      if (v.rv) begin
         chk($sformatf("%s resp_pc", nm), resp_pc, v.erpc);
         chk($sformatf("%s resp_kill", nm), 32'(resp_kill), 32'(v.ekill));
      end
   endtask

   task automatic do_reset(string nm);
      @(negedge clk);
      rst = 1; fetch_ready = 1; resp_valid = 0; stall = 0; redirect = 0; redirect_pc = 0;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("%s fetch_valid", nm), 32'(fetch_valid), 0);
      chk($sformatf("%s target", nm), target, RV);
      chk($sformatf("%s resp_pc", nm), resp_pc, RV);
      chk($sformatf("%s resp_kill", nm), 32'(resp_kill), 0);
      chk($sformatf("%s misalign", nm), 32'(misalign), 0);
      m_pc = RV; m_q.delete(); m_boot = 1; m_hold = 0;
   endtask

   task automatic run_random(int cycles);
      for (int c = 0; c < cycles; c++) begin
         vec_t v;
         bit fl, ok;
         logic [31:0] r;
         fl = 0;
         foreach (m_q[k]) if (m_q[k].kill) fl = 1;
         r = $urandom;
         if ($urandom_range(3) != 0) r[1:0] = 2'b00;
         if ($urandom_range(3) == 0) r[31:4] = '1;
         v.rdy = $urandom_range(3) != 0;
         v.rv = m_q.size() > 0 && $urandom_range(1) == 1;
         v.st = $urandom_range(4) == 0;
         v.rd = !m_boot && !fl && $urandom_range(7) == 0;
         v.rpc = r;
         ok = v.rd && aligned(r) && !m_boot;
         v.emis = v.rd && !aligned(r) && !m_boot;
         v.efv = !m_boot && !fl && !m_hold && !v.st && m_q.size() < MAX && !ok;
         v.etgt = m_pc;
         v.erpc = v.rv ? m_q[0].pc : 32'h0;
         v.ekill = v.rv ? m_q[0].kill : 1'b0;
         step($sformatf("rand%0d", c), v);
         if (v.rv) void'(m_q.pop_front());
         if (v.efv && v.rdy) begin
            m_q.push_back('{pc: m_pc, kill: 1'b0});
            m_pc += 4;
         end
         if (ok) begin
            foreach (m_q[k]) m_q[k].kill = 1'b1;
            m_pc = r;
         end
         m_hold = !m_boot && !fl && v.st && !ok;
         m_boot = 0;
      end
   endtask

   initial begin
      tbl.push_back(mk(1,0,0,0,0,     0,32'h0,  0,0,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'h0,  0,0,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'h4,  0,0,0));
      tbl.push_back(mk(1,1,0,0,0,     0,32'h8,  32'h0,0,0));
      tbl.push_back(mk(0,1,0,0,0,     1,32'h8,  32'h4,0,0));
      tbl.push_back(mk(0,0,0,0,0,     1,32'h8,  0,0,0));
      tbl.push_back(mk(0,0,0,0,0,     1,32'h8,  0,0,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'h8,  0,0,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'hC,  0,0,0));
      tbl.push_back(mk(1,1,0,0,0,     0,32'h10, 32'h8,0,0));
      tbl.push_back(mk(1,1,0,0,0,     1,32'h10, 32'hC,0,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'h14, 0,0,0));
      tbl.push_back(mk(1,0,0,1,32'h100, 0,32'h18, 0,0,0));
      tbl.push_back(mk(1,1,0,0,0,     0,32'h100,32'h10,1,0));
      tbl.push_back(mk(1,0,0,0,0,     0,32'h100,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,     0,32'h100,32'h14,1,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'h100,0,0,0));
      tbl.push_back(mk(1,1,0,0,0,     1,32'h104,32'h100,0,0));
      tbl.push_back(mk(1,0,1,1,32'h200, 0,32'h108,0,0,0));
      tbl.push_back(mk(1,1,1,0,0,     0,32'h200,32'h104,1,0));
      tbl.push_back(mk(1,0,1,0,0,     0,32'h200,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,     0,32'h200,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,     1,32'h200,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,     1,32'h204,32'h200,0,0));
      tbl.push_back(mk(1,0,0,1,32'h300, 0,32'h204,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,     1,32'h300,0,0,0));
      do_reset("reset0");
      foreach (tbl[i]) step($sformatf("row%0d", i), tbl[i]);
      step("mis_issue", mk(1,0,0,0,0, 1,32'h300,0,0,0));
`ifdef PC_GEN_RVC_EN
      step("mis_redir", mk(0,0,0,1,32'h102, 0,32'h304,0,0,0));
      step("mis_resp",  mk(0,1,0,0,0,       0,32'h102,32'h300,1,0));
`else
      step("mis_redir", mk(0,0,0,1,32'h102, 1,32'h304,0,0,1));
      step("mis_resp",  mk(0,1,0,0,0,       1,32'h304,32'h300,0,0));
`endif
      step("wrap_redir", mk(0,0,0,1,32'hFFFF_FFFC, 0,PD,0,0,0));
      step("wrap_issue", mk(1,0,0,0,0, 1,32'hFFFF_FFFC,0,0,0));
      step("wrap_next",  mk(0,1,0,0,0, 1,32'h0,32'hFFFF_FFFC,0,0));
      step("fl_issue0",  mk(1,0,0,0,0, 1,32'h0,0,0,0));
      step("fl_issue1",  mk(1,0,0,0,0, 1,32'h4,0,0,0));
      step("fl_redir",   mk(1,0,0,1,32'h40, 0,32'h8,0,0,0));
      step("fl_resp",    mk(1,1,0,0,0, 0,32'h40,32'h0,1,0));
      do_reset("reset_flush");
      step("rb_boot",  mk(1,0,0,0,0, 0,32'h0,0,0,0));
      step("rb_i0",    mk(1,0,0,0,0, 1,32'h0,0,0,0));
      step("rb_i1",    mk(1,0,0,0,0, 1,32'h4,0,0,0));
      step("rb_full",  mk(0,0,0,0,0, 0,32'h8,0,0,0));
      step("rb_r0",    mk(0,1,0,0,0, 0,32'h8,32'h0,0,0));
      step("rb_r1",    mk(0,1,0,0,0, 1,32'h8,32'h4,0,0));
      do_reset("reset_rand");
      run_random(1500);
      do_reset("reset_rand2");
      run_random(1500);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
